logical_serial: RTL

- Bit-serial, multi-cycle version of the ALU's 8-bit AND/OR logical unit.
- It latches two operands on a START handshake, evaluates one bit per clock, LSB first, and presents the full result with a one-cycle DONE pulse and a ZERO flag.
- It sits beside the combinational ALU path. It serves the multi-cycle datapath variant and is the reference model for checking the combinational unit.
- OP encoding matches the ALU's logical unit: OP=1 selects AND, OP=0 selects OR.

---
 rtl/logical_serial.sv | 136 +++++++++++++
 1 files changed

// File: rtl/logical_serial.sv
// logical_serial: bit-serial AND/OR logical unit.
// Latches two operands on START, evaluates one bit per clock LSB first,
// then publishes the full result on Y with a one-cycle DONE pulse and a
// ZERO flag. OP=1 selects AND, OP=0 selects OR.
module logical_serial #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             OP,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] Y,
    output logic             ZERO
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic [WIDTH-1:0]   r_opA;
    logic [WIDTH-1:0]   w_opANext;
    logic [WIDTH-1:0]   r_opB;
    logic [WIDTH-1:0]   w_opBNext;
    logic               r_op;
    logic               w_opNext;
    logic [WIDTH-1:0]   r_res;
    logic [WIDTH-1:0]   w_resNext;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cntNext;
    logic [WIDTH-1:0]   r_y;
    logic [WIDTH-1:0]   w_yNext;
    logic               r_zero;
    logic               w_zeroNext;
    logic               r_done;
    logic               w_doneNext;
    logic               r_busy;
    logic               w_busyNext;

    logic               w_bit;
    logic [WIDTH-1:0]   w_resShifted;
    logic               w_last;

    // Register every piece of state; reset restores the idle, empty-result condition.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_opA   <= '0;
            r_opB   <= '0;
            r_op    <= 1'b0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_y     <= '0;
            r_zero  <= 1'b1;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_opA   <= w_opANext;
            r_opB   <= w_opBNext;
            r_op    <= w_opNext;
            r_res   <= w_resNext;
            r_cnt   <= w_cntNext;
            r_y     <= w_yNext;
            r_zero  <= w_zeroNext;
            r_done  <= w_doneNext;
            r_busy  <= w_busyNext;
        end
    end

    // Next-state logic: accept a request in IDLE, shift one bit per cycle in SHIFT,
    // and publish the completed word only on the final bit so Y never shows partials.
    always_comb begin
        w_stateNext  = r_state;
        w_opANext    = r_opA;
        w_opBNext    = r_opB;
        w_opNext     = r_op;
        w_resNext    = r_res;
        w_cntNext    = r_cnt;
        w_yNext      = r_y;
        w_zeroNext   = r_zero;
        w_doneNext   = 1'b0;
        w_busyNext   = r_busy;

        w_bit        = r_op ? (r_opA[0] & r_opB[0]) : (r_opA[0] | r_opB[0]);
        w_resShifted = {w_bit, r_res[WIDTH-1:1]};
        w_last       = (r_cnt == CNT_W'(WIDTH - 1));

        case (r_state)
            IDLE: begin
                w_busyNext = 1'b0;
                if (START) begin
                    w_opANext   = A;
                    w_opBNext   = B;
                    w_opNext    = OP;
                    w_resNext   = '0;
                    w_cntNext   = '0;
                    w_busyNext  = 1'b1;
                    w_stateNext = SHIFT;
                end
            end
            SHIFT: begin
                w_resNext = w_resShifted;
                w_opANext = r_opA >> 1;
                w_opBNext = r_opB >> 1;
                w_cntNext = r_cnt + CNT_W'(1);
                if (w_last) begin
                    w_yNext     = w_resShifted;
                    w_zeroNext  = (w_resShifted == '0);
                    w_doneNext  = 1'b1;
                    w_busyNext  = 1'b0;
                    w_cntNext   = '0;
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_busyNext  = 1'b0;
            end
        endcase
    end

    assign BUSY = r_busy;
    assign DONE = r_done;
    assign Y    = r_y;
    assign ZERO = r_zero;

endmodule
